pipelined_shifter: RTL

//  Parametrised, pipelined barrel shifter; successor to the fixed shift-left-by-2 used for branch offsets.

---
 rtl/shifter_pkg.sv | 32 +++
 rtl/pipelined_shifter_shift_stage.sv | 38 +++
 rtl/pipelined_shifter.sv | 93 +++++++++
 3 files changed

// File: rtl/shifter_pkg.sv
// Shared types and stage-partitioning helpers for the pipelined barrel shifter.
package shifter_pkg;

    typedef enum logic [1:0] {
        SH_SLL = 2'b00,
        SH_SRL = 2'b01,
        SH_SRA = 2'b10,
        SH_ROR = 2'b11
    } shift_op_e;

    // Number of shamt bits applied by stage k; the remainder goes to the earliest stages.
    function automatic int unsigned stage_bits(input int unsigned width,
                                               input int unsigned stages,
                                               input int unsigned k);
        int unsigned shw;
        shw = $clog2(width);
        return (shw / stages) + ((k < (shw % stages)) ? 32'd1 : 32'd0);
    endfunction

    // Highest shamt bit applied by stage k; bits are consumed MSB-first.
    function automatic int unsigned stage_hi(input int unsigned width,
                                             input int unsigned stages,
                                             input int unsigned k);
        int unsigned hi;
        hi = $clog2(width) - 1;
        for (int unsigned j = 0; j < k; j++) begin
            hi = hi - stage_bits(width, stages, j);
        end
        return hi;
    endfunction

endpackage

// File: rtl/pipelined_shifter_shift_stage.sv
// One combinational group of log-shifter mux layers covering shamt bits [HI:LO].
// SHIFTER_ROTATE_EN enables the ROR layer; otherwise op 11 passes data through.
module shift_stage
    import shifter_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned HI    = 4,
    parameter int unsigned LO    = 0
) (
    input  logic [WIDTH-1:0] a,
    input  logic [HI-LO:0]   amt,
    input  shift_op_e        op,
    output logic [WIDTH-1:0] y
);
    localparam int unsigned NL = HI - LO + 1;

    // Each layer shifts by a fixed power of two; the loop unrolls into NL mux layers.
    always_comb begin
        int unsigned s;
        s = 0;
        y = a;
        for (int unsigned i = 0; i < NL; i++) begin
            s = 32'd1 << (LO + i);
            if (amt[i]) begin
                case (op)
                    SH_SLL:  y = y << s;
                    SH_SRL:  y = y >> s;
                    SH_SRA:  y = $unsigned($signed(y) >>> s);
`ifdef SHIFTER_ROTATE_EN
                    SH_ROR:  y = (y >> s) | (y << (WIDTH - s));
`endif
                    default: y = y;
                endcase
            end
        end
    end

endmodule

// File: rtl/pipelined_shifter.sv
// Pipelined logarithmic barrel shifter with valid/ready handshake and flush.
// Define SHIFTER_ROTATE_EN to make op 11 a rotate-right; otherwise it is a pass-through.
module pipelined_shifter
    import shifter_pkg::*;
#(
    parameter  int unsigned WIDTH  = 32,
    parameter  int unsigned STAGES = 2,
    localparam int unsigned SHW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [SHW-1:0]   in_shamt,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y
);
    logic              advance;
    logic [STAGES-1:0] vld_q;
    logic [WIDTH-1:0]  dat_q [STAGES];
    shift_op_e         op_q  [STAGES];
    logic [SHW-1:0]    sh_q  [STAGES];

    logic [STAGES-1:0] vld_x;
    logic [WIDTH-1:0]  dat_x [STAGES];
    shift_op_e         op_x  [STAGES];
    logic [SHW-1:0]    sh_x  [STAGES];
    logic [WIDTH-1:0]  dat_y [STAGES];

    // Single global enable: the whole pipe moves unless the result is stuck.
    assign advance   = ~out_valid | out_ready;
    assign in_ready  = advance;
    assign out_valid = vld_q[STAGES-1];
    assign out_y     = dat_q[STAGES-1];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int unsigned HI = stage_hi(WIDTH, STAGES, k);
        localparam int unsigned LO = HI + 1 - stage_bits(WIDTH, STAGES, k);

        if (k == 0) begin : g_head
            assign vld_x[k] = in_valid;
            assign dat_x[k] = in_a;
            assign op_x[k]  = shift_op_e'(in_op);
            assign sh_x[k]  = in_shamt;
        end else begin : g_body
            assign vld_x[k] = vld_q[k-1];
            assign dat_x[k] = dat_q[k-1];
            assign op_x[k]  = op_q[k-1];
            assign sh_x[k]  = sh_q[k-1];
        end

        shift_stage #(
            .WIDTH (WIDTH),
            .HI    (HI),
            .LO    (LO)
        ) u_stage (
            .a   (dat_x[k]),
            .amt (sh_x[k][HI:LO]),
            .op  (op_x[k]),
            .y   (dat_y[k])
        );
    end

    // Pipeline registers; flush only kills valids, data may advance freely.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                dat_q[k] <= '0;
                op_q[k]  <= SH_SLL;
                sh_q[k]  <= '0;
            end
        end else begin
            if (flush) begin
                vld_q <= '0;
            end else if (advance) begin
                vld_q <= vld_x;
            end
            if (advance) begin
                for (int k = 0; k < STAGES; k++) begin
                    dat_q[k] <= dat_y[k];
                    op_q[k]  <= op_x[k];
                    sh_q[k]  <= sh_x[k];
                end
            end
        end
    end

endmodule
